ubrr_config_ctrl: RTL and testbench

- Register-side configuration controller for the USART baud/clock generator.
- Owns shadow copies of UBRRH, UBRRL, UCSRC (shared address with UBRRH, URSEL-selected) and the UCSRA.U2X bit.
- Commits the shadow set atomically to the clock generator only when transmitter and receiver are both idle, or when a timeout expires, so a frame is never corrupted by a baud change.
- Also implements the AVR-style consecutive-read rule for the shared UBRRH/UCSRC address.

---
 rtl/ubrr_config_ctrl.sv | 158 +++++++++++++++
 tb/tb_ubrr_config_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ubrr_config_ctrl.sv
// USART baud/clock configuration controller: shadows UBRRH/UBRRL/UCSRC/U2X and
// commits them atomically to the clock generator once TX and RX are idle (or on timeout).
module ubrr_config_ctrl #(
  parameter int P_TIMEOUT = 4095,
  parameter int P_TW      = 16
) (
  input  logic        i_fosk,
  input  logic        i_rst_n,
  input  logic        i_wr,
  input  logic        i_rd,
  input  logic        i_sel_ubrrh_ucsrc,
  input  logic        i_sel_ubrrl,
  input  logic        i_sel_ucsra,
  input  logic [7:0]  i_wdata,
  input  logic        i_tx_busy,
  input  logic        i_rx_busy,
  output logic [7:0]  o_rdata,
  output logic [11:0] o_UBRR,
  output logic        o_UCPOL,
  output logic        o_UMSEL,
  output logic        o_U2X,
  output logic        o_we_ubrrl,
  output logic [7:0]  o_data,
  output logic        o_pending,
  output logic        o_forced,
  output logic [1:0]  o_dbg_state
);

  // Bus handshake: a strobe (i_wr or i_rd) is accepted in the cycle it is high,
  // provided exactly one address select is active; writes win over reads.

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_IDLE = 2'd1,
    S_COMMIT    = 2'd2
  } state_t;

  localparam logic [P_TW-1:0] TO_LAST = P_TW'(P_TIMEOUT - 1);

  state_t          state;
  logic [P_TW-1:0] cnt;

  logic [11:0] ubrr_sh,  ubrr_nxt;
  logic [6:0]  ucsrc_sh, ucsrc_nxt;
  logic        u2x_sh,   u2x_nxt;
  logic        prev_rd;

  logic one_sel;
  logic wr_ok;
  logic rd_ok;
  logic bus_idle;

  assign one_sel  = $onehot({i_sel_ubrrh_ucsrc, i_sel_ubrrl, i_sel_ucsra});
  assign wr_ok    = i_wr & one_sel;
  assign rd_ok    = i_rd & ~i_wr & one_sel;
  assign bus_idle = ~i_tx_busy & ~i_rx_busy;

  assign o_dbg_state = state;

  // Shadow image including this cycle's write; the commit samples this so a
  // write landing on the deciding edge is part of the committed set.
  always_comb begin
    ubrr_nxt  = ubrr_sh;
    ucsrc_nxt = ucsrc_sh;
    u2x_nxt   = u2x_sh;
    if (wr_ok) begin
      if (i_sel_ubrrh_ucsrc) begin
        if (i_wdata[7]) ucsrc_nxt = i_wdata[6:0];
        else            ubrr_nxt[11:8] = i_wdata[3:0];
      end else if (i_sel_ubrrl) begin
        ubrr_nxt[7:0] = i_wdata;
      end else begin
        u2x_nxt = i_wdata[1];
      end
    end
  end

  always_ff @(posedge i_fosk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ubrr_sh  <= 12'h000;
      ucsrc_sh <= 7'h06;
      u2x_sh   <= 1'b0;
      prev_rd  <= 1'b0;
    end else begin
      ubrr_sh  <= ubrr_nxt;
      ucsrc_sh <= ucsrc_nxt;
      u2x_sh   <= u2x_nxt;
      prev_rd  <= i_rd & i_sel_ubrrh_ucsrc & ~i_wr;
    end
  end

  // Shared address returns UCSRC only on a read directly following a shared read.
  always_comb begin
    o_rdata = 8'h00;
    if (rd_ok) begin
      if (i_sel_ubrrl)      o_rdata = ubrr_sh[7:0];
      else if (i_sel_ucsra) o_rdata = {6'b0, u2x_sh, 1'b0};
      else if (prev_rd)     o_rdata = {1'b1, ucsrc_sh};
      else                  o_rdata = {4'h0, ubrr_sh[11:8]};
    end
  end

  always_ff @(posedge i_fosk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      o_UBRR     <= 12'h000;
      o_UCPOL    <= 1'b0;
      o_UMSEL    <= 1'b0;
      o_U2X      <= 1'b0;
      o_we_ubrrl <= 1'b0;
      o_data     <= 8'h00;
      o_pending  <= 1'b0;
      o_forced   <= 1'b0;
    end else begin
      o_we_ubrrl <= 1'b0;
      o_forced   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr_ok) begin
            state     <= S_WAIT_IDLE;
            cnt       <= '0;
            o_pending <= 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (bus_idle || (cnt == TO_LAST)) begin
            state      <= S_COMMIT;
            o_we_ubrrl <= 1'b1;
            o_forced   <= ~bus_idle;
            o_data     <= ubrr_nxt[7:0];
            o_UBRR     <= ubrr_nxt;
            o_UCPOL    <= ucsrc_nxt[0];
            o_UMSEL    <= ucsrc_nxt[6];
            o_U2X      <= u2x_nxt;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_COMMIT: begin
          // A write during the commit cycle missed this commit; start a new wait.
          if (wr_ok) begin
            state <= S_WAIT_IDLE;
            cnt   <= '0;
          end else begin
            state     <= S_IDLE;
            o_pending <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          o_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ubrr_config_ctrl.sv
// Bench for ubrr_config_ctrl: directed scenarios plus random bus traffic, checked
// against a transaction-level model through expected queues.
module tb_ubrr_config_ctrl;

  localparam int P_TO = 64;

  logic        clk, rst_n;
  logic        wr, rd, s_sh, s_lo, s_a;
  logic [7:0]  wdata;
  logic        tx_busy, rx_busy;
  logic [7:0]  rdata;
  logic [11:0] ubrr;
  logic        ucpol, umsel, u2x, we_ubrrl, pending, forced;
  logic [7:0]  odata;
  logic [1:0]  dbg_state;

  ubrr_config_ctrl #(.P_TIMEOUT(P_TO), .P_TW(16)) dut (
    .i_fosk(clk), .i_rst_n(rst_n), .i_wr(wr), .i_rd(rd),
    .i_sel_ubrrh_ucsrc(s_sh), .i_sel_ubrrl(s_lo), .i_sel_ucsra(s_a),
    .i_wdata(wdata), .i_tx_busy(tx_busy), .i_rx_busy(rx_busy),
    .o_rdata(rdata), .o_UBRR(ubrr), .o_UCPOL(ucpol), .o_UMSEL(umsel),
    .o_U2X(u2x), .o_we_ubrrl(we_ubrrl), .o_data(odata),
    .o_pending(pending), .o_forced(forced), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [11:0] ubrr;
    logic [7:0]  data;
    logic        forced;
  } commit_t;

  commit_t     cm_q[$];
  logic [7:0]  exp_q[$];

  logic [11:0] m_ubrr;
  logic [6:0]  m_ucsrc;
  logic        m_u2x, m_prev_rd;
  logic [11:0] m_c_ubrr;
  logic        m_c_ucpol, m_c_umsel, m_c_u2x;
  bit          m_wait, m_commit_now, m_forced_now;
  int          m_cnt;

  task automatic model_reset();
    m_ubrr = 12'h000; m_ucsrc = 7'h06; m_u2x = 1'b0; m_prev_rd = 1'b0;
    m_c_ubrr = 12'h000; m_c_ucpol = 1'b0; m_c_umsel = 1'b0; m_c_u2x = 1'b0;
    m_wait = 0; m_commit_now = 0; m_forced_now = 0; m_cnt = 0;
    cm_q.delete();
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        logic [11:0] nu; logic [6:0] nc; logic na;
        bit wr_ok, idle;
        commit_t c;
        wr_ok = wr && $onehot({s_sh, s_lo, s_a});
        idle  = !tx_busy && !rx_busy;
        nu = m_ubrr; nc = m_ucsrc; na = m_u2x;
        if (wr_ok) begin
          if (s_sh && wdata[7]) nc = wdata[6:0];
          else if (s_sh)        nu = {wdata[3:0], m_ubrr[7:0]};
          else if (s_lo)        nu = {m_ubrr[11:8], wdata};
          else                  na = wdata[1];
        end
        m_commit_now = 0;
        m_forced_now = 0;
        if (m_wait) begin
          if (idle || m_cnt == P_TO - 1) begin
            m_wait = 0;
            m_commit_now = 1;
            m_forced_now = !idle;
            m_c_ubrr = nu; m_c_ucpol = nc[0]; m_c_umsel = nc[6]; m_c_u2x = na;
            c.ubrr = nu; c.data = nu[7:0]; c.forced = !idle;
            cm_q.push_back(c);
          end else begin
            m_cnt++;
          end
        end else if (wr_ok) begin
          m_wait = 1;
          m_cnt = 0;
        end
        m_prev_rd = rd && s_sh && !wr;
        m_ubrr = nu; m_ucsrc = nc; m_u2x = na;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("we_ubrrl", we_ubrrl, m_commit_now);
      chk("forced", forced, m_forced_now);
      chk("pending", pending, m_wait || m_commit_now);
      chk("o_UBRR", ubrr, m_c_ubrr);
      chk("o_UCPOL", ucpol, m_c_ucpol);
      chk("o_UMSEL", umsel, m_c_umsel);
      chk("o_U2X", u2x, m_c_u2x);
      if (we_ubrrl === 1'b1) begin
        if (cm_q.size() == 0) begin
          chk("commit_unexpected", 1, 0);
        end else begin
          commit_t c;
          c = cm_q.pop_front();
          chk("o_data", odata, c.data);
          chk("commit_ubrr", ubrr, c.ubrr);
        end
      end
      if (rd === 1'b1) begin
        if (exp_q.size() == 0) chk("read_unexpected", 1, 0);
        else chk("o_rdata", rdata, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  // sel = {shared, ubrrl, ucsra}
  task automatic drive(input bit w, input bit r, input logic [2:0] sel,
                       input logic [7:0] d, input bit tx, input bit rx);
    logic [7:0] e;
    @(posedge clk);
    #1;
    wr = w; rd = r; {s_sh, s_lo, s_a} = sel; wdata = d; tx_busy = tx; rx_busy = rx;
    if (r) begin
      if (w || !$onehot(sel)) e = 8'h00;
      else if (sel[1])        e = m_ubrr[7:0];
      else if (sel[0])        e = {6'b0, m_u2x, 1'b0};
      else if (m_prev_rd)     e = {1'b1, m_ucsrc};
      else                    e = {4'h0, m_ubrr[11:8]};
      exp_q.push_back(e);
    end
  endtask

  task automatic idle_cycles(input int n, input bit tx, input bit rx);
    for (int i = 0; i < n; i++) drive(0, 0, 3'b000, 8'h00, tx, rx);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit tx_r, rx_r;
    wr = 0; rd = 0; s_sh = 0; s_lo = 0; s_a = 0; wdata = 0; tx_busy = 0; rx_busy = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    idle_cycles(2, 0, 0);
    chk("reset_ubrr", ubrr, 12'h000);
    chk("reset_pending", pending, 0);

    // back-to-back shared reads: UBRRH then UCSRC
    drive(0, 1, 3'b100, 8'h00, 0, 0);
    drive(0, 1, 3'b100, 8'h00, 0, 0);
    idle_cycles(1, 0, 0);

    // UBRRH then UBRRL with the bus idle
    drive(1, 0, 3'b100, 8'h05, 0, 0);
    drive(1, 0, 3'b010, 8'h3F, 0, 0);
    idle_cycles(4, 0, 0);
    chk("dir_ubrr_53f", ubrr, 12'h53F);
    chk("dir_pending_low", pending, 0);

    // transmitter held busy: forced commit after the timeout
    drive(1, 0, 3'b010, 8'h10, 1, 0);
    idle_cycles(P_TO - 2, 1, 0);
    chk("dir_held_ubrr", ubrr, 12'h53F);
    idle_cycles(5, 1, 0);
    chk("dir_forced_ubrr", ubrr, 12'h510);

    // receiver busy, UCSRC write, busy released after 20 cycles
    drive(1, 0, 3'b100, 8'hC1, 0, 1);
    idle_cycles(19, 0, 1);
    idle_cycles(4, 0, 0);
    chk("dir_ucpol", ucpol, 1);
    chk("dir_umsel", umsel, 1);

    // write landing in the COMMIT cycle of a previous write
    drive(1, 0, 3'b010, 8'h55, 0, 0);
    idle_cycles(1, 0, 0);
    drive(1, 0, 3'b010, 8'hAA, 0, 0);
    idle_cycles(5, 0, 0);
    chk("dir_second_commit", ubrr[7:0], 8'hAA);

    // reset during WAIT_IDLE discards the pending commit
    drive(1, 0, 3'b010, 8'h77, 1, 0);
    idle_cycles(5, 1, 0);
    #3 rst_n = 0;
    #1;
    chk("rst_pending", pending, 0);
    chk("rst_ubrr", ubrr, 12'h000);
    chk("rst_ucpol", ucpol, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    idle_cycles(10, 0, 0);
    chk("rst_no_commit", ubrr, 12'h000);

    // random traffic
    tx_r = 0; rx_r = 0;
    for (int i = 0; i < 1500; i++) begin
      bit w, r;
      logic [2:0] sel;
      if ($urandom_range(0, 15) == 0) tx_r = !tx_r;
      if ($urandom_range(0, 15) == 0) rx_r = !rx_r;
      w = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 9))
        0:       sel = 3'($urandom_range(0, 7));
        1, 2, 3: sel = 3'b100;
        4, 5, 6: sel = 3'b010;
        default: sel = 3'b001;
      endcase
      drive(w, r, sel, 8'($urandom_range(0, 255)), tx_r, rx_r);
    end
    idle_cycles(P_TO + 4, 0, 0);

    chk("commit_queue_empty", cm_q.size(), 0);
    chk("read_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
